lynx_kbd: RTL



---
 rtl/lynx_kbd.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lynx_kbd.sv
// PS/2 set-2 keyboard receiver driving a 10x8 active-low Lynx key matrix read by row select.
// Optional build macro LYNX_KBD_PARITY_CHECK_EN enables odd-parity checking and the parity_err strobe.
module lynx_kbd #(
  parameter int TIMEOUT = 16384,
  parameter int NROWS   = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] ps2,
  input  logic [3:0] row,
  output logic [7:0] cols,
  output logic       kb_valid,
  output logic [7:0] kb_code,
  output logic       kb_ext,
  output logic       kb_release,
  output logic       parity_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_e;

  logic [1:0]    ps2_s1_q, ps2_s2_q;
  logic          clk_prev_q;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          acc_q, acc_d;
  logic [7:0]    acc_byte_q;
  logic          fall, dat, stop_ok;

  logic [7:0]    mat_q [NROWS];
  logic [7:0]    mat_d [NROWS];
  logic          lsh_q, lsh_d, rsh_q, rsh_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic          kv_q, kv_d, kext_q, kext_d, krel_q, krel_d;
  logic [7:0]    code_q, code_d, cols_q;
  logic [7:0]    map;

  assign fall    = clk_prev_q & ~ps2_s2_q[0];
  assign dat     = ps2_s2_q[1];
  assign stop_ok = shreg_q[9];

  // {hit, row[3:0], col[2:0]} indexed by {E0 prefix, scancode}
  function automatic logic [7:0] key_map(input logic [8:0] k);
    case (k)
      9'h01C: key_map = {1'b1, 4'd3, 3'd6};
      9'h029: key_map = {1'b1, 4'd9, 3'd0};
      9'h05A: key_map = {1'b1, 4'd8, 3'd3};
      9'h012,
      9'h059: key_map = {1'b1, 4'd0, 3'd0};
      9'h175: key_map = {1'b1, 4'd1, 3'd4};
      9'h172: key_map = {1'b1, 4'd2, 3'd4};
      9'h016: key_map = {1'b1, 4'd0, 3'd1};
      9'h076: key_map = {1'b1, 4'd0, 3'd2};
      9'h01E: key_map = {1'b1, 4'd1, 3'd1};
      9'h026: key_map = {1'b1, 4'd2, 3'd1};
      9'h015: key_map = {1'b1, 4'd1, 3'd6};
      9'h01D: key_map = {1'b1, 4'd2, 3'd6};
      9'h01B: key_map = {1'b1, 4'd3, 3'd5};
      9'h022: key_map = {1'b1, 4'd4, 3'd5};
      9'h014: key_map = {1'b1, 4'd7, 3'd7};
      9'h066: key_map = {1'b1, 4'd8, 3'd5};
      9'h16B: key_map = {1'b1, 4'd8, 3'd4};
      9'h174: key_map = {1'b1, 4'd9, 3'd4};
      default: key_map = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tmo_d   = tmo_q;
    acc_d   = 1'b0;
    case (state_q)
      S_IDLE: if (fall && !dat) begin
        state_d = S_SHIFT;
        cnt_d   = 4'd0;
        tmo_d   = TW'(TIMEOUT - 1);
      end
      S_SHIFT: begin
        if (fall) begin
          shreg_d = {dat, shreg_q[9:1]};
          tmo_d   = TW'(TIMEOUT - 1);
          if (cnt_q == 4'd9) state_d = S_CHECK;
          else cnt_d = cnt_q + 4'd1;
        end else if (tmo_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_CHECK: begin
`ifdef LYNX_KBD_PARITY_CHECK_EN
        acc_d = stop_ok & (^shreg_q[8:0]);
`else
        acc_d = stop_ok;
`endif
        state_d = S_IDLE;
        // a start bit landing right after the stop bit must not be dropped
        if (fall && !dat) begin
          state_d = S_SHIFT;
          cnt_d   = 4'd0;
          tmo_d   = TW'(TIMEOUT - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LYNX_KBD_PARITY_CHECK_EN
  assign parity_err = (state_q == S_CHECK) && stop_ok && !(^shreg_q[8:0]);
`else
  logic unused_par;
  assign unused_par = shreg_q[8];
  assign parity_err = 1'b0;
`endif

  always_comb begin
    mat_d  = mat_q;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    kv_d   = 1'b0;
    code_d = code_q;
    kext_d = kext_q;
    krel_d = krel_q;
    map    = key_map({ext_q, acc_byte_q});
    if (acc_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (acc_byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: rel_d = 1'b1;
          8'hE1: skip_d = 3'd7;
          8'hAA: begin
            mat_d = '{default: 8'hFF};
            lsh_d = 1'b0;
            rsh_d = 1'b0;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
          default: begin
            kv_d   = 1'b1;
            code_d = acc_byte_q;
            kext_d = ext_q;
            krel_d = rel_q;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            if (map[7]) begin
              if (!ext_q && acc_byte_q == 8'h12) lsh_d = !rel_q;
              if (!ext_q && acc_byte_q == 8'h59) rsh_d = !rel_q;
              if (!ext_q && (acc_byte_q == 8'h12 || acc_byte_q == 8'h59))
                mat_d[map[6:3]][map[2:0]] = !(lsh_d | rsh_d);
              else
                mat_d[map[6:3]][map[2:0]] = rel_q;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps2_s1_q   <= 2'b11;
      ps2_s2_q   <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shreg_q    <= 10'd0;
      tmo_q      <= '0;
      acc_q      <= 1'b0;
      acc_byte_q <= 8'h00;
      mat_q      <= '{default: 8'hFF};
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      skip_q     <= 3'd0;
      kv_q       <= 1'b0;
      code_q     <= 8'h00;
      kext_q     <= 1'b0;
      krel_q     <= 1'b0;
      cols_q     <= 8'hFF;
    end else begin
      ps2_s1_q   <= ps2;
      ps2_s2_q   <= ps2_s1_q;
      clk_prev_q <= ps2_s2_q[0];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      if (state_q == S_CHECK) acc_byte_q <= shreg_q[7:0];
      mat_q      <= mat_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      skip_q     <= skip_d;
      kv_q       <= kv_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      krel_q     <= krel_d;
      cols_q     <= (int'(row) < NROWS) ? mat_q[row] : 8'hFF;
    end
  end

  assign cols       = cols_q;
  assign kb_valid   = kv_q;
  assign kb_code    = code_q;
  assign kb_ext     = kext_q;
  assign kb_release = krel_q;
endmodule
